vector_writeback_merger: RTL and testbench
==========================================

VECTOR_WRITEBACK_MERGER -- requirements
Module: vector_writeback_merger

Interface
REQ-001 SHALL have parameter VECTOR_MASK_LENGTH, default 8, number of elements per vector.
REQ-002 SHALL have parameter ELEMENT_WIDTH, default 8, bits per element; VW = VECTOR_MASK_LENGTH*ELEMENT_WIDTH.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port in_destination_register  input  5  destination vector register index.
REQ-008 SHALL have port in_result_vector  input  VW  computed result; element i = bits [i*ELEMENT_WIDTH +: ELEMENT_WIDTH].
REQ-009 SHALL have port in_vector_mask  input  VECTOR_MASK_LENGTH  bit i = 1 means element i is active.
REQ-010 SHALL have port in_tail_mask  input  VECTOR_MASK_LENGTH  bit i = 1 means element i is tail (vector tail encoder output).
REQ-011 SHALL have port in_mask_agnostic  input  1  1 = masked-off elements agnostic, 0 = undisturbed.
REQ-012 SHALL have port in_tail_agnostic  input  1  1 = tail elements agnostic, 0 = undisturbed.
REQ-013 SHALL have port register_read_enable  output  1  one-cycle read strobe to the vector register file.
REQ-014 SHALL have port register_read_address  output  5  read index.
REQ-015 SHALL have port register_read_data  input  VW  old register contents, valid the cycle after register_read_enable.
REQ-016 SHALL have port register_write_enable  output  1  one-cycle write strobe.
REQ-017 SHALL have port register_write_address  output  5  write index.
REQ-018 SHALL have port register_write_data  output  VW  merged vector.
REQ-019 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, READ, MERGE, WRITE.
REQ-021 Accept SHALL occur when in_valid && in_ready; all in_* inputs are captured on accept and held until the request's write completes.
REQ-022 in_ready SHALL be 1 in IDLE and WRITE, 0 in READ and MERGE.
REQ-023 Per-element resolution SHALL be: tail bit = 1 -> tail policy (takes precedence over mask bit); else mask bit = 1 -> result element; else mask policy.
REQ-024 Agnostic policy SHALL write all-ones; undisturbed policy SHALL write the old register element.
REQ-025 needs_old SHALL be 1 iff at least one element resolves to undisturbed.
REQ-026 On accept with needs_old = 0: next state WRITE; merged data is computed from captured inputs; no register read is issued.
REQ-027 On accept with needs_old = 1: next state READ; READ asserts register_read_enable = 1 with register_read_address = captured destination for exactly one cycle, then MERGE.
REQ-028 MERGE SHALL register the merge of the captured result with register_read_data, then go to WRITE.
REQ-029 WRITE SHALL assert register_write_enable = 1 for exactly one cycle with register_write_address = captured destination and register_write_data = merged vector.
REQ-030 Latency from the accept cycle N SHALL be: write at N+1 without a read; read at N+1, write at N+3 with a read.
REQ-031 From WRITE: if a new request is accepted, SHALL go to WRITE or READ per REQ-026/027; otherwise SHALL go to IDLE.
REQ-032 A read issued the cycle after a write to the same register SHALL see the newly written data, since the register file updates on the write edge.
REQ-033 register_read_enable and register_write_enable SHALL never both be 1 for the same request; outputs not strobed hold their last values.

Reset
REQ-034 While reset = 1: state = IDLE; register_read_enable = 0; register_write_enable = 0; busy = 0; addresses and write data = 0; in_ready = 0 during the reset cycle and 1 from the first cycle after reset.
REQ-035 Reset asserted in READ, MERGE or WRITE SHALL abort the request; no write strobe follows deassertion.

Verification (VECTOR_MASK_LENGTH = 8, ELEMENT_WIDTH = 8)
REQ-036 mask 0xFF, tail 0x00, result elements 0x01..0x08, dest 3 -> no read; write at N+1 to register 3 with data = result.
REQ-037 mask 0x0F, tail 0xC0, both policies undisturbed, old elements 0xAA -> read register 3 at N+1, write at N+3; elements 0-3 = result, elements 4-7 = 0xAA.
REQ-038 Same inputs as REQ-037 with both policies agnostic -> no read; write at N+1; elements 4-7 = 0xFF.
REQ-039 mask 0xFF, tail 0xF0, tail agnostic -> elements 4-7 = 0xFF, elements 0-3 = result (tail precedence).
REQ-040 Second request presented during WRITE -> accepted that cycle; its read or write follows at the next cycle with no idle gap.
REQ-041 reset pulsed during MERGE -> no register_write_enable afterwards; in_ready = 1 and busy = 0 on the first cycle after reset.

Source files
------------

// File: rtl/vector_writeback_merger.sv
`default_nettype none
// ============================================================================
// Module      : vector_writeback_merger
// Description : Merges a computed vector result into its destination vector
//               register. Each element is resolved from the tail mask, the
//               active mask and the agnostic/undisturbed policies. Agnostic
//               elements are written as all-ones. Undisturbed elements keep
//               the old register value. A register read is issued only when
//               at least one element resolves to undisturbed.
//
// Ports       : clock, reset                 - clock, sync active-high reset
//               in_valid / in_ready          - request handshake
//               in_destination_register      - destination register index
//               in_result_vector             - computed result vector
//               in_vector_mask / in_tail_mask- per-element active / tail bits
//               in_mask_agnostic / in_tail_agnostic - element policies
//               register_read_*              - old-value read port (1-cycle)
//               register_write_*             - merged-value write port
//               busy                         - high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module vector_writeback_merger #(
    parameter int VECTOR_MASK_LENGTH = 8,
    parameter int ELEMENT_WIDTH      = 8
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [4:0]                                  in_destination_register,
    input  logic [VECTOR_MASK_LENGTH*ELEMENT_WIDTH-1:0] in_result_vector,
    input  logic [VECTOR_MASK_LENGTH-1:0]               in_vector_mask,
    input  logic [VECTOR_MASK_LENGTH-1:0]               in_tail_mask,
    input  logic                                        in_mask_agnostic,
    input  logic                                        in_tail_agnostic,
    output logic                                        register_read_enable,
    output logic [4:0]                                  register_read_address,
    input  logic [VECTOR_MASK_LENGTH*ELEMENT_WIDTH-1:0] register_read_data,
    output logic                                        register_write_enable,
    output logic [4:0]                                  register_write_address,
    output logic [VECTOR_MASK_LENGTH*ELEMENT_WIDTH-1:0] register_write_data,
    output logic                                        busy
);

    localparam int VW = VECTOR_MASK_LENGTH * ELEMENT_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_MERGE = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    // Tail takes precedence over the active mask; otherwise active elements
    // take the result and inactive ones follow the mask policy.
    function automatic logic [VW-1:0] merge_vec(
        input logic [VW-1:0]                 res,
        input logic [VW-1:0]                 old,
        input logic [VECTOR_MASK_LENGTH-1:0] mask,
        input logic [VECTOR_MASK_LENGTH-1:0] tail,
        input logic                          mask_agn,
        input logic                          tail_agn
    );
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < VECTOR_MASK_LENGTH; i++) begin
            if (tail[i]) begin
                v[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] = tail_agn ? {ELEMENT_WIDTH{1'b1}}
                                                               : old[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
            end else if (mask[i]) begin
                v[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] = res[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
            end else begin
                v[i*ELEMENT_WIDTH +: ELEMENT_WIDTH] = mask_agn ? {ELEMENT_WIDTH{1'b1}}
                                                               : old[i*ELEMENT_WIDTH +: ELEMENT_WIDTH];
            end
        end
        return v;
    endfunction

    logic [1:0]                    state_q,    state_d;
    logic [4:0]                    dest_q,     dest_d;
    logic [VW-1:0]                 result_q,   result_d;
    logic [VECTOR_MASK_LENGTH-1:0] mask_q,     mask_d;
    logic [VECTOR_MASK_LENGTH-1:0] tail_q,     tail_d;
    logic                          mask_agn_q, mask_agn_d;
    logic                          tail_agn_q, tail_agn_d;
    logic [4:0]                    rd_addr_q,  rd_addr_d;
    logic [4:0]                    wr_addr_q,  wr_addr_d;
    logic [VW-1:0]                 wr_data_q,  wr_data_d;

    logic accept;
    logic needs_old;

    // An undisturbed element exists if some tail element is undisturbed, or
    // some non-tail inactive element is undisturbed.
    assign needs_old = (!in_tail_agnostic && (|in_tail_mask)) ||
                       (!in_mask_agnostic && (|(~in_tail_mask & ~in_vector_mask)));

    assign in_ready = !reset && ((state_q == ST_IDLE) || (state_q == ST_WRITE));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        result_d   = result_q;
        mask_d     = mask_q;
        tail_d     = tail_q;
        mask_agn_d = mask_agn_q;
        tail_agn_d = tail_agn_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            ST_IDLE, ST_WRITE: begin
                if (accept) begin
                    dest_d     = in_destination_register;
                    result_d   = in_result_vector;
                    mask_d     = in_vector_mask;
                    tail_d     = in_tail_mask;
                    mask_agn_d = in_mask_agnostic;
                    tail_agn_d = in_tail_agnostic;
                    if (needs_old) begin
                        state_d   = ST_READ;
                        rd_addr_d = in_destination_register;
                    end else begin
                        // No element needs the old value, so the merge can
                        // be formed straight from the request.
                        state_d   = ST_WRITE;
                        wr_addr_d = in_destination_register;
                        wr_data_d = merge_vec(in_result_vector, '0, in_vector_mask,
                                              in_tail_mask, in_mask_agnostic,
                                              in_tail_agnostic);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                state_d = ST_MERGE;
            end
            ST_MERGE: begin
                // Read data is valid the cycle after the read strobe.
                state_d   = ST_WRITE;
                wr_addr_d = dest_q;
                wr_data_d = merge_vec(result_q, register_read_data, mask_q, tail_q,
                                      mask_agn_q, tail_agn_q);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            dest_q     <= '0;
            result_q   <= '0;
            mask_q     <= '0;
            tail_q     <= '0;
            mask_agn_q <= 1'b0;
            tail_agn_q <= 1'b0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            result_q   <= result_d;
            mask_q     <= mask_d;
            tail_q     <= tail_d;
            mask_agn_q <= mask_agn_d;
            tail_agn_q <= tail_agn_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Strobes and busy are qualified by reset so they are low for the whole
    // reset cycle, including the first one before any edge has been seen.
    assign register_read_enable   = !reset && (state_q == ST_READ);
    assign register_write_enable  = !reset && (state_q == ST_WRITE);
    assign busy                   = !reset && (state_q != ST_IDLE);
    assign register_read_address  = rd_addr_q;
    assign register_write_address = wr_addr_q;
    assign register_write_data    = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_vector_writeback_merger.sv
`default_nettype none
// ============================================================================
// Module      : tb_vector_writeback_merger
// Description : Self-checking bench for vector_writeback_merger. A behavioural
//               model schedules the expected read/write strobes per request
//               and a register-file model supplies old data. Directed
//               requests with hand-computed results pin the model, followed
//               by randomized traffic with occasional resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vector_writeback_merger;

    localparam int VL = 8;
    localparam int EW = 8;
    localparam int VW = VL * EW;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_destination_register;
    logic [VW-1:0] in_result_vector;
    logic [VL-1:0] in_vector_mask;
    logic [VL-1:0] in_tail_mask;
    logic          in_mask_agnostic;
    logic          in_tail_agnostic;
    logic          register_read_enable;
    logic [4:0]    register_read_address;
    logic [VW-1:0] register_read_data;
    logic          register_write_enable;
    logic [4:0]    register_write_address;
    logic [VW-1:0] register_write_data;
    logic          busy;

    vector_writeback_merger #(
        .VECTOR_MASK_LENGTH (VL),
        .ELEMENT_WIDTH      (EW)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .in_destination_register (in_destination_register),
        .in_result_vector        (in_result_vector),
        .in_vector_mask          (in_vector_mask),
        .in_tail_mask            (in_tail_mask),
        .in_mask_agnostic        (in_mask_agnostic),
        .in_tail_agnostic        (in_tail_agnostic),
        .register_read_enable    (register_read_enable),
        .register_read_address   (register_read_address),
        .register_read_data      (register_read_data),
        .register_write_enable   (register_write_enable),
        .register_write_address  (register_write_address),
        .register_write_data     (register_write_data),
        .busy                    (busy)
    );

    always #5 clock = ~clock;

    // ---------------- shared bench state ----------------
    int            cyc = 0;
    logic [VW-1:0] seed_mem  [32];
    logic [VW-1:0] mem       [32];   // register file seen by the DUT
    logic [VW-1:0] model_mem [32];   // register file as the model expects it
    logic          mem_init = 1'b1;
    logic          done = 1'b0;
    logic          timeout_req = 1'b0;

    // written by the compare process only
    int            errors = 0;
    int            checks = 0;
    int            exp_rd_cyc = -1;
    int            exp_wr_cyc = -1;
    logic [4:0]    exp_rd_addr = '0;
    logic [4:0]    exp_wr_addr = '0;
    logic [VW-1:0] exp_wr_data = '0;
    bit            last_acc = 1'b0;
    int            acc_cyc = -1;
    bit            rst_prev = 1'b0;

    // hand-computed expectations, written by the stimulus process only
    int            lit_wr_cyc = -1;
    logic [4:0]    lit_wr_addr = '0;
    logic [VW-1:0] lit_wr_data = '0;
    int            lit_rd_cyc = -1;
    bit            lit_rd_exp = 1'b0;
    int            lit_idle_cyc = -1;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= seed_mem[i];
        end else begin
            if (register_write_enable) mem[register_write_address] <= register_write_data;
            if (register_read_enable)  register_read_data <= mem[register_read_address];
        end
    end

    // Element-by-element writeback rule; also reports how many elements keep
    // their old value.
    function automatic logic [VW-1:0] model_merge(
        input logic [VW-1:0] res, input logic [VW-1:0] old,
        input logic [VL-1:0] m, input logic [VL-1:0] t,
        input logic ma, input logic ta, output int n_keep);
        logic [VW-1:0] o;
        bit keep;
        o = '0;
        n_keep = 0;
        for (int e = 0; e < VL; e++) begin
            keep = t[e] ? !ta : (m[e] ? 1'b0 : !ma);
            if (keep)                o[e*EW +: EW] = old[e*EW +: EW];
            else if (!t[e] && m[e])  o[e*EW +: EW] = res[e*EW +: EW];
            else                     o[e*EW +: EW] = 8'hFF;
            if (keep) n_keep++;
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        bit            ready_e, busy_e;
        int            n_keep;
        logic [VW-1:0] d;
        if (done) begin
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
        if (reset) begin
            if (mem_init) for (int i = 0; i < 32; i++) model_mem[i] = seed_mem[i];
            chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
            chk("rst_busy", {63'd0, busy}, 64'd0);
            chk("rst_rd_en", {63'd0, register_read_enable}, 64'd0);
            chk("rst_wr_en", {63'd0, register_write_enable}, 64'd0);
            if (rst_prev) begin
                chk("rst_rd_addr", {59'd0, register_read_address}, 64'd0);
                chk("rst_wr_addr", {59'd0, register_write_address}, 64'd0);
                chk("rst_wr_data", register_write_data, 64'd0);
            end
            exp_rd_cyc = -1;
            exp_wr_cyc = -1;
            last_acc   = 1'b0;
            rst_prev   = 1'b1;
        end else begin
            rst_prev = 1'b0;
            // Ready iff nothing of an accepted request is still to come after
            // this cycle; busy iff anything is due now or later.
            ready_e = !((exp_rd_cyc >= cyc) || (exp_wr_cyc > cyc));
            busy_e  = (exp_rd_cyc >= cyc) || (exp_wr_cyc >= cyc);
            chk("in_ready", {63'd0, in_ready}, {63'd0, ready_e});
            chk("busy", {63'd0, busy}, {63'd0, busy_e});
            chk("rd_en", {63'd0, register_read_enable}, {63'd0, (cyc == exp_rd_cyc)});
            chk("wr_en", {63'd0, register_write_enable}, {63'd0, (cyc == exp_wr_cyc)});
            chk("accept_timeout", {63'd0, timeout_req}, 64'd0);
            if (cyc == exp_rd_cyc)
                chk("rd_addr", {59'd0, register_read_address}, {59'd0, exp_rd_addr});
            if (cyc == exp_wr_cyc) begin
                chk("wr_addr", {59'd0, register_write_address}, {59'd0, exp_wr_addr});
                chk("wr_data", register_write_data, exp_wr_data);
                model_mem[exp_wr_addr] = exp_wr_data;
            end
            if (cyc == lit_wr_cyc) begin
                chk("lit_wr_en", {63'd0, register_write_enable}, 64'd1);
                chk("lit_wr_addr", {59'd0, register_write_address}, {59'd0, lit_wr_addr});
                chk("lit_wr_data", register_write_data, lit_wr_data);
            end
            if (cyc == lit_rd_cyc)
                chk("lit_rd_en", {63'd0, register_read_enable}, {63'd0, lit_rd_exp});
            if (cyc == lit_idle_cyc) begin
                chk("post_rst_ready", {63'd0, in_ready}, 64'd1);
                chk("post_rst_busy", {63'd0, busy}, 64'd0);
                chk("post_rst_wr_en", {63'd0, register_write_enable}, 64'd0);
            end
            last_acc = in_valid && ready_e;
            if (last_acc) begin
                acc_cyc = cyc;
                d = model_merge(in_result_vector, model_mem[in_destination_register],
                                in_vector_mask, in_tail_mask, in_mask_agnostic,
                                in_tail_agnostic, n_keep);
                exp_wr_addr = in_destination_register;
                exp_wr_data = d;
                if (n_keep > 0) begin
                    exp_rd_cyc  = cyc + 1;
                    exp_rd_addr = in_destination_register;
                    exp_wr_cyc  = cyc + 3;
                end else begin
                    exp_wr_cyc  = cyc + 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [4:0] d, input logic [VW-1:0] r,
                         input logic [VL-1:0] m, input logic [VL-1:0] t,
                         input logic ma, input logic ta,
                         input bit rd_exp, input int lat, input logic [VW-1:0] wd);
        int budget;
        #1;
        in_valid                = 1'b1;
        in_destination_register = d;
        in_result_vector        = r;
        in_vector_mask          = m;
        in_tail_mask            = t;
        in_mask_agnostic        = ma;
        in_tail_agnostic        = ta;
        budget = 0;
        do begin
            @(posedge clock);
            budget++;
        end while (!last_acc && budget < 20);
        if (!last_acc) begin
            timeout_req = 1'b1;
            @(negedge clock);
            #1 timeout_req = 1'b0;
        end else begin
            lit_rd_cyc = acc_cyc + 1;
            lit_rd_exp = rd_exp;
            if (lat > 0) begin
                lit_wr_cyc  = acc_cyc + lat;
                lit_wr_addr = d;
                lit_wr_data = wd;
            end
        end
    endtask

    localparam logic [VW-1:0] R1 = 64'h0807060504030201;

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_destination_register = '0;
        in_result_vector = '0;
        in_vector_mask = '0;
        in_tail_mask = '0;
        in_mask_agnostic = 1'b0;
        in_tail_agnostic = 1'b0;
        for (int i = 0; i < 32; i++) seed_mem[i] = {$urandom, $urandom};
        seed_mem[3] = {8{8'hAA}};
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        mem_init = 1'b0;
        @(posedge clock);

        // undisturbed mask + tail on old 0xAA: read then write three later
        issue(5'd3, R1, 8'h0F, 8'hC0, 1'b0, 1'b0, 1'b1, 3, 64'hAAAAAAAA_04030201);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clock);
        // all active, no tail: direct write
        issue(5'd3, R1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1, R1);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clock);
        // both agnostic: no read, inactive and tail elements all-ones
        issue(5'd3, R1, 8'h0F, 8'hC0, 1'b1, 1'b1, 1'b0, 1, 64'hFFFFFFFF_04030201);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clock);
        // tail overrides an active mask bit
        issue(5'd5, R1, 8'hFF, 8'hF0, 1'b0, 1'b1, 1'b0, 1, 64'hFFFFFFFF_04030201);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clock);

        // back-to-back requests accepted in WRITE; the last one reads the
        // register written by the one before it
        issue(5'd3, R1, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 1, R1);
        issue(5'd4, 64'hDEADBEEF_CAFEF00D, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 1,
              64'hDEADBEEF_CAFEF00D);
        issue(5'd4, 64'h11223344_55667788, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b1, 3,
              64'hDEADBEEF_55667788);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clock);

        // reset pulsed during MERGE aborts the request
        issue(5'd6, R1, 8'h0F, 8'h00, 1'b0, 1'b0, 1'b1, 0, '0);
        lit_idle_cyc = acc_cyc + 3;
        #1 in_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            #1;
            reset                   = ($urandom_range(0, 59) == 0);
            in_valid                = ($urandom_range(0, 2) != 0);
            in_destination_register = 5'($urandom_range(0, 3));
            in_result_vector        = {$urandom, $urandom};
            in_vector_mask          = 8'($urandom);
            in_tail_mask            = 8'hFF << $urandom_range(0, 8);
            in_mask_agnostic        = 1'($urandom);
            in_tail_agnostic        = 1'($urandom);
            @(posedge clock);
        end
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        repeat (6) @(posedge clock);
        done = 1'b1;
    end

endmodule
`default_nettype wire
